tdc_multichan: RTL and testbench



---
 rtl/tdc_multichan.sv | 162 ++++++++++++++++
 tb/tb_tdc_multichan.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_multichan.sv
`default_nettype none
// ============================================================================
//  Module      : tdc_multichan
//  Description : Multi-channel time-to-digital converter. Counts clk cycles
//                from a start edge to the first stop edge on each channel and
//                then streams one result word per channel over valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module tdc_multichan #(
    parameter int          CHANNELS = 4,
    parameter int          WIDTH    = 16,
    parameter int unsigned TIMEOUT  = (1 << WIDTH) - 1,
    localparam int         CHAN_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CHANNELS-1:0] stop,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [CHAN_W-1:0]   out_chan,
    output logic [WIDTH-1:0]    out_time,
    output logic                out_hit,
    output logic                busy
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_MEASURE = 2'd1;
    localparam logic [1:0] S_READOUT = 2'd2;

    localparam logic [WIDTH-1:0]  C_TIMEOUT = TIMEOUT[WIDTH-1:0];
    localparam logic [CHAN_W-1:0] C_LAST    = CHAN_W'(CHANNELS - 1);

    logic [1:0]          r_state;
    logic                r_start_q;
    logic [CHANNELS-1:0] r_stop_q;
    logic [WIDTH-1:0]    r_count;
    logic [CHANNELS-1:0] r_hit;
    logic [WIDTH-1:0]    r_time [CHANNELS];
    logic [CHAN_W-1:0]   r_rd_idx;
    logic                r_out_valid;
    logic [CHAN_W-1:0]   r_out_chan;
    logic [WIDTH-1:0]    r_out_time;
    logic                r_out_hit;
    logic                r_busy;

    logic [1:0]          w_state_nxt;
    logic [WIDTH-1:0]    w_count_nxt;
    logic [CHANNELS-1:0] w_hit_nxt;
    logic [WIDTH-1:0]    w_time_nxt [CHANNELS];
    logic [CHAN_W-1:0]   w_rd_idx_nxt;
    logic [CHANNELS-1:0] w_new_hit;
    logic                w_start_edge;
    logic [CHANNELS-1:0] w_stop_edge;
    logic                w_out_valid_nxt;
    logic [CHAN_W-1:0]   w_out_chan_nxt;
    logic [WIDTH-1:0]    w_out_time_nxt;
    logic                w_out_hit_nxt;

    assign w_start_edge = start & ~r_start_q;
    assign w_stop_edge  = stop & ~r_stop_q;

    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_hit_nxt    = r_hit;
        w_time_nxt   = r_time;
        w_rd_idx_nxt = r_rd_idx;
        w_new_hit    = '0;
        case (r_state)
            S_IDLE: begin
                w_count_nxt = '0;
                if (w_start_edge) begin
                    w_state_nxt = S_MEASURE;
                    w_count_nxt = WIDTH'(1);
                    w_hit_nxt   = '0;
                    for (int i = 0; i < CHANNELS; i++) begin
                        w_time_nxt[i] = '0;
                    end
                end
            end
            S_MEASURE: begin
                if (r_count != '1) begin
                    w_count_nxt = r_count + WIDTH'(1);
                end
                w_new_hit = w_stop_edge & ~r_hit;
                for (int i = 0; i < CHANNELS; i++) begin
                    if (w_new_hit[i]) begin
                        w_time_nxt[i] = r_count;
                    end
                end
                w_hit_nxt = r_hit | w_new_hit;
                // Hits landing on this edge count towards the all-hit exit.
                if ((&w_hit_nxt) || (r_count == C_TIMEOUT)) begin
                    w_state_nxt  = S_READOUT;
                    w_rd_idx_nxt = '0;
                end
            end
            S_READOUT: begin
                if (r_out_valid && out_ready) begin
                    if (r_rd_idx == C_LAST) begin
                        w_state_nxt = S_IDLE;
                        w_count_nxt = '0;
                    end else begin
                        w_rd_idx_nxt = r_rd_idx + CHAN_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_count_nxt = '0;
            end
        endcase

        // Output word is built from next-state values so it is registered
        // yet already correct on the first READOUT cycle.
        w_out_valid_nxt = (w_state_nxt == S_READOUT);
        w_out_chan_nxt  = w_out_valid_nxt ? w_rd_idx_nxt : '0;
        w_out_hit_nxt   = w_out_valid_nxt & w_hit_nxt[w_rd_idx_nxt];
        w_out_time_nxt  = w_out_hit_nxt ? w_time_nxt[w_rd_idx_nxt] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_start_q   <= 1'b1;
            r_stop_q    <= '1;
            r_count     <= '0;
            r_hit       <= '0;
            r_rd_idx    <= '0;
            r_out_valid <= 1'b0;
            r_out_chan  <= '0;
            r_out_time  <= '0;
            r_out_hit   <= 1'b0;
            r_busy      <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_time[i] <= '0;
            end
        end else begin
            r_state     <= w_state_nxt;
            r_start_q   <= start;
            r_stop_q    <= stop;
            r_count     <= w_count_nxt;
            r_hit       <= w_hit_nxt;
            r_time      <= w_time_nxt;
            r_rd_idx    <= w_rd_idx_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_chan  <= w_out_chan_nxt;
            r_out_time  <= w_out_time_nxt;
            r_out_hit   <= w_out_hit_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
        end
    end

    assign out_valid = r_out_valid;
    assign out_chan  = r_out_chan;
    assign out_time  = r_out_time;
    assign out_hit   = r_out_hit;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_tdc_multichan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tdc_multichan
//  Description : Scoreboard bench for tdc_multichan; expected words come from
//                stop-pulse offsets relative to the start edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tdc_multichan;

    localparam int CHANNELS = 4;
    localparam int WIDTH    = 16;
    localparam int TIMEOUT  = 120;

    typedef struct {
        int ch;
        int tm;
        int hit;
    } result_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [CHANNELS-1:0] stop;
    logic                out_ready;
    logic                out_valid;
    logic [1:0]          out_chan;
    logic [WIDTH-1:0]    out_time;
    logic                out_hit;
    logic                busy;

    result_t exp_q[$];
    int      n_checks = 0;
    int      n_pass   = 0;
    int      pl [CHANNELS][4];
    int      np [CHANNELS];
    int      stall_cnt;

    tdc_multichan #(
        .CHANNELS (CHANNELS),
        .WIDTH    (WIDTH),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_chan  (out_chan),
        .out_time  (out_time),
        .out_hit   (out_hit),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Monitor: one sample per cycle, just after the driver's negedge update.
    result_t e;
    logic    prev_stall = 1'b0;
    logic [1:0]       prev_chan;
    logic [WIDTH-1:0] prev_time;
    logic             prev_hit;
    always begin
        @(negedge clk);
        #1;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                n_checks++;
                if (out_valid && out_chan == prev_chan && out_time == prev_time && out_hit == prev_hit)
                    n_pass++;
                else
                    $display("FAIL hold: got v=%0d (%0d,%0d,%0d), expected v=1 (%0d,%0d,%0d)",
                             out_valid, out_chan, out_time, out_hit, prev_chan, prev_time, prev_hit);
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_word: got (%0d,%0d,%0d), expected no word",
                             out_chan, out_time, out_hit);
                end else begin
                    e = exp_q.pop_front();
                    if (int'(out_chan) == e.ch && int'(out_time) == e.tm && int'(out_hit) == e.hit)
                        n_pass++;
                    else
                        $display("FAIL result: got (%0d,%0d,%0d), expected (%0d,%0d,%0d)",
                                 out_chan, out_time, out_hit, e.ch, e.tm, e.hit);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_chan  = out_chan;
            prev_time  = out_time;
            prev_hit   = out_hit;
        end
    end

    task automatic clear_pulses();
        for (int c = 0; c < CHANNELS; c++) np[c] = 0;
    endtask

    task automatic add_pulse(input int c, input int k);
        pl[c][np[c]] = k;
        np[c]++;
    endtask

    task automatic gen_random();
        int p;
        int n;
        clear_pulses();
        for (int c = 0; c < CHANNELS; c++) begin
            p = $urandom_range(0, 60);
            n = $urandom_range(0, 3);
            for (int j = 0; j < n; j++) begin
                if (p <= TIMEOUT + 3) add_pulse(c, p);
                p += $urandom_range(2, 50);
            end
        end
    endtask

    function automatic bit has_pulse(input int c, input int k);
        for (int j = 0; j < np[c]; j++) if (pl[c][j] == k) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive_ready(input int mode);
        case (mode)
            0: out_ready = ($urandom_range(0, 99) < 70);
            1: out_ready = 1'b1;
            default: begin
                out_ready = out_valid && (stall_cnt >= 5);
                if (out_valid && stall_cnt < 5) stall_cnt++;
            end
        endcase
    endtask

    // One measurement: model the results from the pulse offsets, then play them.
    task automatic run_meas(input int mode, input int abort_at, input bit start_last);
        int  f [CHANNELS];
        bit  h [CHANNELS];
        bit  all_hit;
        int  end_k;
        int  s_extra;
        int  kmax;
        bit  fired;
        bit  done;
        result_t r;

        all_hit = 1'b1;
        end_k   = 0;
        for (int c = 0; c < CHANNELS; c++) begin
            h[c] = 1'b0;
            f[c] = 0;
            for (int j = 0; j < np[c]; j++) begin
                if (!h[c] && pl[c][j] >= 1 && pl[c][j] <= TIMEOUT) begin
                    h[c] = 1'b1;
                    f[c] = pl[c][j];
                end
            end
            if (!h[c]) all_hit = 1'b0;
            if (f[c] > end_k) end_k = f[c];
        end
        if (!all_hit) end_k = TIMEOUT;
        if (abort_at < 0) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r.ch  = c;
                r.tm  = h[c] ? f[c] : 0;
                r.hit = h[c] ? 1 : 0;
                exp_q.push_back(r);
            end
        end

        stall_cnt = 0;
        s_extra   = (end_k >= 3) ? int'($urandom_range(2, end_k - 1)) : -1;
        kmax      = (abort_at >= 0) ? abort_at : end_k + 1;
        for (int k = 0; k <= kmax; k++) begin
            @(negedge clk);
            if (abort_at < 0) begin
                if (k == 1)         check("busy_measure", busy, 1);
                if (k == end_k)     check("valid_before_end", out_valid, 0);
                if (k == end_k + 1) check("valid_at_end", out_valid, 1);
            end
            start = (k == 0) || (k == s_extra) || (k == end_k + 1);
            for (int c = 0; c < CHANNELS; c++) stop[c] = has_pulse(c, k);
            drive_ready(mode);
        end

        if (abort_at >= 0) begin
            @(negedge clk);
            rst   = 1'b1;
            start = 1'b1;
            stop  = '1;
            repeat (2) @(negedge clk);
            rst = 1'b0;
            repeat (3) @(negedge clk);
            check("abort_valid", out_valid, 0);
            check("abort_busy",  busy, 0);
            check("abort_chan",  out_chan, 0);
            check("abort_time",  out_time, 0);
            check("abort_hit",   out_hit, 0);
            start = 1'b0;
            stop  = '0;
            repeat (2) @(negedge clk);
            check("abort_no_edge", busy, 0);
            return;
        end

        fired = 1'b0;
        done  = 1'b0;
        for (int w = 0; w < 300 && !done; w++) begin
            @(negedge clk);
            stop = '0;
            if (exp_q.size() == 0 && !out_valid && !busy) begin
                done = 1'b1;
            end else if (start_last && !fired && out_valid && out_chan == 2'(CHANNELS - 1)) begin
                out_ready = 1'b1;
                start     = 1'b1;
                fired     = 1'b1;
            end else begin
                if (!fired) start = 1'b0;
                drive_ready(mode);
            end
        end
        if (!done) begin
            check("readout_wait_bound", 0, 1);
            exp_q.delete();
        end
        check("idle_busy", busy, 0);
        check("idle_valid", out_valid, 0);
        if (fired) begin
            repeat (3) @(negedge clk);
            check("start_on_last_ignored", busy, 0);
        end
        start     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        stop      = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_busy",  busy, 0);
        check("rst_chan",  out_chan, 0);
        check("rst_time",  out_time, 0);
        check("rst_hit",   out_hit, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Basic four-channel measurement with a shared time on channels 1 and 2.
        clear_pulses();
        add_pulse(0, 3); add_pulse(1, 10); add_pulse(2, 10); add_pulse(3, 100);
        run_meas(1, -1, 1'b0);

        // Only channel 1 fires; the rest time out.
        clear_pulses();
        add_pulse(1, 7);
        run_meas(1, -1, 1'b0);

        // Backpressure on the first word.
        clear_pulses();
        add_pulse(0, 3); add_pulse(1, 10); add_pulse(2, 10); add_pulse(3, 40);
        run_meas(2, -1, 1'b0);

        // Repeated stop edges on channel 2.
        clear_pulses();
        add_pulse(0, 2); add_pulse(1, 6); add_pulse(2, 4); add_pulse(2, 9); add_pulse(3, 12);
        run_meas(1, -1, 1'b0);

        // Stop coincident with start, and a stop exactly at TIMEOUT.
        clear_pulses();
        add_pulse(0, 0); add_pulse(0, TIMEOUT);
        run_meas(0, -1, 1'b0);

        // Reset mid-measurement, then a clean measurement.
        clear_pulses();
        add_pulse(0, 50);
        run_meas(1, 10, 1'b0);
        clear_pulses();
        add_pulse(0, 5); add_pulse(1, 6); add_pulse(2, 7); add_pulse(3, 8);
        run_meas(1, -1, 1'b0);

        // Start edge coincident with the last transfer.
        clear_pulses();
        add_pulse(0, 1); add_pulse(1, 2); add_pulse(2, 3); add_pulse(3, 4);
        run_meas(1, -1, 1'b1);

        for (int t = 0; t < 25; t++) begin
            gen_random();
            run_meas(0, -1, 1'b0);
        end

        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of run, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
